// File: rtl/analog_drive_pkg.sv
// Shared types, defaults and the code-to-voltage conversion for analog_drive.
package analog_drive_pkg;

  localparam int unsigned CODE_W_DEF        = 12;
  localparam int unsigned STEP_DEF          = 16;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Map a DAC code onto [0, vfs]; full scale is code 2**code_w-1.
  function automatic real code_to_volts(input logic [31:0] code,
                                        input int unsigned code_w,
                                        input real         vfs);
    real full;
    full = real'((64'd1 << code_w) - 64'd1);
    return real'(code) * vfs / full;
  endfunction

endpackage

// File: rtl/analog_drive_if.sv
// Request handshake plus the driven code/voltage and status of analog_drive.
interface analog_drive_if #(
  parameter int unsigned CODE_W = 12
);

  logic              req_valid;
  logic              req_ready;
  logic [CODE_W-1:0] req_code;
  logic              abort;
  logic [CODE_W-1:0] code;
  real               voltage;
  logic              busy;
  logic              done;

  modport master (
    output req_valid, req_code, abort,
    input  req_ready, code, voltage, busy, done
  );

  modport slave (
    input  req_valid, req_code, abort,
    output req_ready, code, voltage, busy, done
  );

endinterface

// File: rtl/analog_drive.sv
// Slew-limited DAC code source: ramps toward an accepted target by at most
// STEP per clock, holds for SETTLE_CYCLES, then pulses done.
module analog_drive
  import analog_drive_pkg::*;
#(
  parameter int unsigned CODE_W        = CODE_W_DEF,
  parameter int unsigned STEP          = STEP_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter real         VFS           = 3.3
) (
  input  logic           clk,
  input  logic           reset_n,
  analog_drive_if.slave  bus
);

  localparam int unsigned DIFF_W = CODE_W + 1;
  localparam int unsigned CNT_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [DIFF_W-1:0] STEP_V   = DIFF_W'(STEP);
  localparam logic [CNT_W-1:0]  SETTLE_V = CNT_W'(SETTLE_CYCLES);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic signed [DIFF_W-1:0] diff_c;
  logic [DIFF_W-1:0]        mag_c;
  logic [DIFF_W-1:0]        step_c;

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, slew step and settle countdown.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    // Signed distance is one bit wider than the code so it never wraps.
    diff_c = signed'({1'b0, target_q}) - signed'({1'b0, code_q});
    mag_c  = diff_c[DIFF_W-1] ? DIFF_W'(-diff_c) : DIFF_W'(diff_c);
    step_c = (mag_c > STEP_V) ? STEP_V : mag_c;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          target_d = bus.req_code;
          if (bus.req_code == code_q) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_V;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          code_d = diff_c[DIFF_W-1] ? code_q - CODE_W'(step_c)
                                    : code_q + CODE_W'(step_c);
          if (mag_c == step_c) begin
            state_d = SETTLE;
            cnt_d   = SETTLE_V;
          end
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.req_ready = ready_q;
  assign bus.code      = code_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.voltage   = code_to_volts(32'(code_q), CODE_W, VFS);

endmodule

// File: tb/tb_analog_drive.sv
// Directed bench for analog_drive: ramps, clamping, zero distance,
// back-to-back requests, abort and reset mid-ramp.
module tb_analog_drive;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  analog_drive_if #(.CODE_W(12)) bus ();

  analog_drive #(
    .CODE_W        (12),
    .STEP          (16),
    .SETTLE_CYCLES (4),
    .VFS           (3.3)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input real obs, input real exp);
    real d;
    d = obs - exp;
    if (d < 0.0) d = -d;
    n_vec++;
    assert (d < 1.0e-4) else begin
      n_err++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [11:0] c);
    bus.req_valid = 1'b1;
    bus.req_code  = c;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int up_tbl [7];
    int dn_tbl [7];
    int n;
    up_tbl = '{16, 32, 48, 64, 80, 96, 100};
    dn_tbl = '{84, 68, 52, 36, 20, 4, 0};
    n_vec = 0;
    n_err = 0;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_code  = '0;
    bus.abort     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_code", 32'(bus.code), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk_v("rst_volt", bus.voltage, 0.0);
    reset_n = 1'b1;
    tick();
    chk("rel_ready", 32'(bus.req_ready), 1);

    // Ramp up 0 -> 100
    request(12'd100);
    chk("up_busy0", 32'(bus.busy), 1);
    chk("up_ready0", 32'(bus.req_ready), 0);
    chk("up_code0", 32'(bus.code), 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("up_code%0d", i + 1), 32'(bus.code), 32'(up_tbl[i]));
    end
    for (int i = 8; i <= 11; i++) begin
      tick();
      chk($sformatf("up_settle_done%0d", i), 32'(bus.done), 0);
    end
    chk("up_busy11", 32'(bus.busy), 1);
    tick();
    chk("up_done12", 32'(bus.done), 1);
    chk("up_busy12", 32'(bus.busy), 0);
    chk("up_ready12", 32'(bus.req_ready), 1);
    chk_v("up_volt", bus.voltage, 0.0805861);
    tick();
    chk("up_done_pulse", 32'(bus.done), 0);

    // Zero distance at 100
    request(12'd100);
    for (int i = 0; i <= 4; i++) begin
      chk($sformatf("zd_busy%0d", i), 32'(bus.busy), 1);
      chk($sformatf("zd_done%0d", i), 32'(bus.done), 0);
      tick();
    end
    chk("zd_done5", 32'(bus.done), 1);
    chk("zd_busy5", 32'(bus.busy), 0);
    chk("zd_code", 32'(bus.code), 100);
    tick();

    // Ramp down 100 -> 0, clamps at zero without wrapping
    request(12'd0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i <= 7) chk($sformatf("dn_code%0d", i), 32'(bus.code), 32'(dn_tbl[i-1]));
      chk($sformatf("dn_done%0d", i), 32'(bus.done), (i == 12) ? 1 : 0);
    end
    chk("dn_code_final", 32'(bus.code), 0);
    tick();

    // Back-to-back: 4095 held valid while a 0 -> 64 ramp runs
    request(12'd64);
    bus.req_valid = 1'b1;
    bus.req_code  = 12'd4095;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("bb_ready%0d", i), 32'(bus.req_ready), 0);
    end
    chk("bb_code8", 32'(bus.code), 64);
    tick();
    chk("bb_done9", 32'(bus.done), 1);
    chk("bb_ready9", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    chk("bb_accept_busy", 32'(bus.busy), 1);
    chk("bb_accept_code", 32'(bus.code), 64);
    tick();
    chk("bb_first_step", 32'(bus.code), 80);
    n = 1;
    while (bus.done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("bb_done_latency", 32'(n), 257);
    chk("bb_code_final", 32'(bus.code), 4095);
    chk_v("bb_volt_final", bus.voltage, 3.3);

    // Reset mid-ramp
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    request(12'd4000);
    for (int i = 1; i <= 4; i++) tick();
    chk("rm_code_pre", 32'(bus.code), 64);
    reset_n = 1'b0;
    tick();
    chk("rm_code", 32'(bus.code), 0);
    chk("rm_busy", 32'(bus.busy), 0);
    chk("rm_done", 32'(bus.done), 0);
    chk("rm_ready", 32'(bus.req_ready), 0);
    tick();
    chk("rm_ready_held", 32'(bus.req_ready), 0);
    reset_n = 1'b1;
    tick();
    chk("rm_ready_rel", 32'(bus.req_ready), 1);

    // Abort during ramp after edge 3
    request(12'd4000);
    for (int i = 1; i <= 3; i++) tick();
    chk("ab_code3", 32'(bus.code), 48);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_code", 32'(bus.code), 48);
    chk("ab_busy", 32'(bus.busy), 0);
    chk("ab_ready", 32'(bus.req_ready), 1);
    chk("ab_done", 32'(bus.done), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("ab_nodone%0d", i), 32'(bus.done), 0);
    end
    chk("ab_code_hold", 32'(bus.code), 48);

    // Abort during settle; abort in IDLE has no effect
    request(12'd60);
    tick();
    chk("as_code", 32'(bus.code), 60);
    bus.abort = 1'b1;
    tick();
    chk("as_busy", 32'(bus.busy), 0);
    chk("as_done", 32'(bus.done), 0);
    tick();
    chk("as_idle_code", 32'(bus.code), 60);
    chk("as_idle_ready", 32'(bus.req_ready), 1);
    chk("as_idle_done", 32'(bus.done), 0);
    bus.abort = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
